// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the 16x-oversampled UART receiver.
//   uart_state_e  - receiver FSM states
//   OVERSAMPLE    - oversample ticks per bit
//   SMP_LO/MID/HI - sample-counter values at which the line is sampled
//   SC_LAST       - last sample-counter value of a bit (bit boundary follows)
//   DATA_BITS     - data bits per frame
//   majority3()   - 2-of-3 vote used for every bit decision
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StWaitHigh
    } uart_state_e;

    localparam int unsigned OVERSAMPLE = 16;
    localparam logic [3:0]  SMP_LO     = 4'd7;
    localparam logic [3:0]  SMP_MID    = 4'd8;
    localparam logic [3:0]  SMP_HI     = 4'd9;
    localparam logic [3:0]  SC_LAST    = 4'd15;
    localparam int unsigned DATA_BITS  = 8;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running divider producing the 16x oversample tick.
// Parameters:
//   DIV      sysclk cycles per tick
// Ports:
//   sysclk   system clock
//   reset    asynchronous, active-low reset
//   restart  synchronous restart; counter is 0 on the following cycle
//   tick     one-cycle pulse while the counter sits at DIV-1
module uart_baud_tick #(
    parameter int unsigned DIV = 651
) (
    input  logic sysclk,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam int unsigned   CW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (restart || (cnt_q == CNT_MAX)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == CNT_MAX);

endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: 16x-oversampled UART receiver, 8N1 by default.
// Optional: define UART_RX_PARITY_EN for 8E1 frames (even parity bit after the data).
// Parameters:
//   CLK_FREQ   sysclk frequency in Hz
//   BAUD       line rate in bit/s
// Ports:
//   sysclk     system clock
//   reset      asynchronous, active-low reset
//   UART_RX    asynchronous serial input, idle high
//   RX_DATA    last correctly received byte (held between frames)
//   RX_STATUS  one-cycle pulse when RX_DATA is updated
//   RX_ERR     one-cycle pulse on a framing or parity error
module uart_receiver #(
    parameter int unsigned CLK_FREQ = 100000000,
    parameter int unsigned BAUD     = 9600
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       UART_RX,
    output logic [7:0] RX_DATA,
    output logic       RX_STATUS,
    output logic       RX_ERR
);

    import uart_pkg::*;

    localparam int unsigned DIV      = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam logic [3:0]  BITS_ALL = 4'(DATA_BITS);

    logic        rx_meta_q, rx_s_q, rx_prev_q;
    uart_state_e state_q, state_d;
    logic [3:0]  sc_q, sc_d, sc_next;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic        s7_q, s7_d, s8_q, s8_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        status_q, status_d;
    logic        err_q, err_d;
    logic        tick, start_edge, decide, wrap, bit_val;
`ifdef UART_RX_PARITY_EN
    logic        par_err_q, par_err_d;
`endif

    // Counter is restarted on the start edge so tick n lands n*DIV cycles after it.
    assign start_edge = (state_q == StIdle) && rx_prev_q && !rx_s_q;

    uart_baud_tick #(
        .DIV (DIV)
    ) u_baud_tick (
        .sysclk  (sysclk),
        .reset   (reset),
        .restart (start_edge),
        .tick    (tick)
    );

    // Actions are keyed on the value sc takes after this tick.
    assign sc_next = sc_q + 4'd1;
    assign decide  = tick && (sc_next == SMP_HI);
    assign wrap    = tick && (sc_q == SC_LAST);
    assign bit_val = majority3(s7_q, s8_q, rx_s_q);

    always_comb begin
        state_d   = state_q;
        sc_d      = sc_q;
        bit_cnt_d = bit_cnt_q;
        s7_d      = s7_q;
        s8_d      = s8_q;
        shreg_d   = shreg_q;
        rx_data_d = rx_data_q;
        status_d  = 1'b0;
        err_d     = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_err_d = par_err_q;
`endif

        if (tick && (state_q != StIdle) && (state_q != StWaitHigh)) begin
            sc_d = sc_next;
            if (sc_next == SMP_LO) begin
                s7_d = rx_s_q;
            end
            if (sc_next == SMP_MID) begin
                s8_d = rx_s_q;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (start_edge) begin
                    state_d   = StStart;
                    sc_d      = '0;
                    bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
                    par_err_d = 1'b0;
`endif
                end
            end
            StStart: begin
                // A high vote at mid-start is a glitch, not a frame.
                if (decide) begin
                    state_d = bit_val ? StIdle : StData;
                end
            end
            StData: begin
                if (decide) begin
                    shreg_d   = {bit_val, shreg_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
                // The first wrap seen here ends the start bit; bit_cnt is still 0 then.
                if (wrap && (bit_cnt_q == BITS_ALL)) begin
`ifdef UART_RX_PARITY_EN
                    state_d = StParity;
`else
                    state_d = StStop;
`endif
                end
            end
            StParity: begin
`ifdef UART_RX_PARITY_EN
                if (decide) begin
                    par_err_d = ^{shreg_q, bit_val};
                end
                if (wrap) begin
                    state_d = StStop;
                end
`else
                state_d = StIdle;
`endif
            end
            StStop: begin
                // Leave mid-stop so a start bit directly after the stop bit is caught.
                if (decide) begin
                    if (!bit_val) begin
                        err_d   = 1'b1;
                        state_d = StWaitHigh;
                    end else begin
                        state_d = StIdle;
`ifdef UART_RX_PARITY_EN
                        if (par_err_q) begin
                            err_d = 1'b1;
                        end else begin
                            rx_data_d = shreg_q;
                            status_d  = 1'b1;
                        end
`else
                        rx_data_d = shreg_q;
                        status_d  = 1'b1;
`endif
                    end
                end
            end
            StWaitHigh: begin
                // A stuck-low line must return high before a new start is accepted.
                if (rx_s_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
            state_q   <= StIdle;
            sc_q      <= '0;
            bit_cnt_q <= '0;
            s7_q      <= 1'b0;
            s8_q      <= 1'b0;
            shreg_q   <= '0;
            rx_data_q <= '0;
            status_q  <= 1'b0;
            err_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err_q <= 1'b0;
`endif
        end else begin
            rx_meta_q <= UART_RX;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
            state_q   <= state_d;
            sc_q      <= sc_d;
            bit_cnt_q <= bit_cnt_d;
            s7_q      <= s7_d;
            s8_q      <= s8_d;
            shreg_q   <= shreg_d;
            rx_data_q <= rx_data_d;
            status_q  <= status_d;
            err_q     <= err_d;
`ifdef UART_RX_PARITY_EN
            par_err_q <= par_err_d;
`endif
        end
    end

    assign RX_DATA   = rx_data_q;
    assign RX_STATUS = status_q;
    assign RX_ERR    = err_q;

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: table-driven, hand-written and randomized frames for uart_receiver.
// Runs with a small divider (DIV=4, 64 sysclk per bit) to keep frames short.
module tb_uart_receiver;

    localparam int unsigned CLK_FREQ = 640000;
    localparam int unsigned BAUD     = 10000;
    localparam int          DIV      = 4;
    localparam int          BITT     = 16 * DIV;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       sysclk  = 1'b0;
    logic       reset   = 1'b0;
    logic       UART_RX = 1'b1;
    logic [7:0] RX_DATA;
    logic       RX_STATUS;
    logic       RX_ERR;

    always #5 sysclk = ~sysclk;

    uart_receiver #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) dut (
        .sysclk    (sysclk),
        .reset     (reset),
        .UART_RX   (UART_RX),
        .RX_DATA   (RX_DATA),
        .RX_STATUS (RX_STATUS),
        .RX_ERR    (RX_ERR)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Pulse monitor: counts strobes and captures the byte presented with each one.
    int         st_cnt   = 0;
    int         err_cnt  = 0;
    int         both_cnt = 0;
    logic [7:0] obs_q[$];

    always @(negedge sysclk) begin
        if (RX_STATUS === 1'b1) begin
            st_cnt++;
            obs_q.push_back(RX_DATA);
        end
        if (RX_ERR === 1'b1) err_cnt++;
        if (RX_STATUS === 1'b1 && RX_ERR === 1'b1) both_cnt++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    endtask

    // Drives one frame, one value per sysclk, changing on the falling edge.
    // spike_c >= 0 forces the line high for DIV cycles centred on that cycle.
    task automatic drive_frame(input logic [7:0] d, input logic stop, input logic par_bad,
                               input int spike_c, input int max_c);
        logic [10:0] bits;
        int          nb;
        bits    = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = d[i];
        if (PAR_EN) begin
            bits[9]  = (^d) ^ par_bad;
            bits[10] = stop;
            nb       = 11;
        end else begin
            bits[9] = stop;
            nb      = 10;
        end
        for (int c = 0; c < nb * BITT && c < max_c; c++) begin
            UART_RX = bits[c / BITT];
            if (spike_c >= 0 && c >= spike_c - DIV / 2 && c < spike_c + DIV / 2) UART_RX = 1'b1;
            @(negedge sysclk);
        end
    endtask

    task automatic line_for(input logic v, input int cycles);
        UART_RX = v;
        repeat (cycles) @(negedge sysclk);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       par_bad;
        int         low_bits;
        int         gap_bits;
        logic [7:0] exp_data;
        int         exp_st;
        int         exp_err;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int         s0, e0;
        logic [7:0] d, model_data, got;
        logic       stop, pb, ok;
        int         gap, low;

        vecs.push_back('{8'h55, 1'b1, 1'b0, 0, 2, 8'h55, 1, 0});
        vecs.push_back('{8'hA3, 1'b1, 1'b0, 0, 0, 8'hA3, 1, 0});
        vecs.push_back('{8'h0F, 1'b1, 1'b0, 0, 2, 8'h0F, 1, 0});
        vecs.push_back('{8'h81, 1'b0, 1'b0, 2, 2, 8'h0F, 0, 1});
        vecs.push_back('{8'h42, 1'b1, 1'b0, 0, 2, 8'h42, 1, 0});
        vecs.push_back('{8'hC6, 1'b1, 1'b0, 0, 1, 8'hC6, 1, 0});
`ifdef UART_RX_PARITY_EN
        vecs.push_back('{8'h07, 1'b1, 1'b1, 0, 2, 8'hC6, 0, 1});
        vecs.push_back('{8'h07, 1'b1, 1'b0, 0, 2, 8'h07, 1, 0});
        vecs.push_back('{8'h5A, 1'b0, 1'b1, 0, 2, 8'h07, 0, 1});
`endif

        // Reset state.
        repeat (3) @(negedge sysclk);
        check("reset RX_DATA", RX_DATA, 8'h00);
        check("reset RX_STATUS", RX_STATUS, 1'b0);
        check("reset RX_ERR", RX_ERR, 1'b0);
        reset = 1'b1;
        line_for(1'b1, 2 * BITT);

        foreach (vecs[i]) begin
            s0 = st_cnt;
            e0 = err_cnt;
            drive_frame(vecs[i].data, vecs[i].stop, vecs[i].par_bad, -1, 1 << 30);
            if (vecs[i].low_bits > 0) line_for(1'b0, vecs[i].low_bits * BITT);
            line_for(1'b1, vecs[i].gap_bits * BITT);
            check($sformatf("vec%0d status pulses", i), st_cnt - s0, vecs[i].exp_st);
            check($sformatf("vec%0d err pulses", i), err_cnt - e0, vecs[i].exp_err);
            check($sformatf("vec%0d RX_DATA", i), RX_DATA, vecs[i].exp_data);
        end

        // Start glitch of 4 ticks must not produce a frame.
        s0 = st_cnt;
        e0 = err_cnt;
        line_for(1'b0, 4 * DIV);
        line_for(1'b1, 2 * BITT);
        check("glitch status pulses", st_cnt - s0, 0);
        check("glitch err pulses", err_cnt - e0, 0);
        drive_frame(8'h3C, 1'b1, 1'b0, -1, 1 << 30);
        line_for(1'b1, 2 * BITT);
        check("after glitch status pulses", st_cnt - s0, 1);
        check("after glitch RX_DATA", RX_DATA, 8'h3C);

        // Single-sample spike on data bit 2 at sc=8 is outvoted.
        s0 = st_cnt;
        drive_frame(8'h00, 1'b1, 1'b0, (16 * 3 + 8) * DIV, 1 << 30);
        line_for(1'b1, BITT);
        check("spike status pulses", st_cnt - s0, 1);
        check("spike RX_DATA", RX_DATA, 8'h00);

        // Reset in the middle of data bit 4 of 0xF0 aborts the frame.
        s0 = st_cnt;
        e0 = err_cnt;
        drive_frame(8'hF0, 1'b1, 1'b0, -1, 5 * BITT + BITT / 2);
        reset = 1'b0;
        line_for(1'b1, 3);
        check("midframe reset RX_DATA", RX_DATA, 8'h00);
        check("midframe reset RX_STATUS", RX_STATUS, 1'b0);
        reset = 1'b1;
        line_for(1'b1, 2 * BITT);
        check("aborted frame status pulses", st_cnt - s0, 0);
        check("aborted frame err pulses", err_cnt - e0, 0);
        drive_frame(8'hFF, 1'b1, 1'b0, -1, 1 << 30);
        line_for(1'b1, 2 * BITT);
        check("post-reset status pulses", st_cnt - s0, 1);
        check("post-reset RX_DATA", RX_DATA, 8'hFF);

        // Randomized frames against the frame-level model.
        model_data = 8'hFF;
        for (int n = 0; n < 24; n++) begin
            d    = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            pb   = PAR_EN && ($urandom_range(0, 3) == 0);
            gap  = stop ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
            low  = stop ? 0 : int'($urandom_range(0, 1));
            ok   = stop && !pb;
            if (ok) model_data = d;
            s0 = st_cnt;
            e0 = err_cnt;
            obs_q.delete();
            drive_frame(d, stop, pb, -1, 1 << 30);
            if (low > 0) line_for(1'b0, low * BITT);
            line_for(1'b1, gap * BITT);
            check($sformatf("rand%0d status pulses", n), st_cnt - s0, ok ? 1 : 0);
            check($sformatf("rand%0d err pulses", n), err_cnt - e0, ok ? 0 : 1);
            check($sformatf("rand%0d RX_DATA", n), RX_DATA, model_data);
            if (ok) begin
                got = (obs_q.size() > 0) ? obs_q[0] : 8'hxx;
                check($sformatf("rand%0d strobed byte", n), got, d);
            end
        end

        check("status/err overlap cycles", both_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
